// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory, the downstream
// decode stage and the execute-stage redirect source.
interface fetch_sequencer_if #(
  parameter int MEM_ADDR_WIDTH = 10
);
  // Instruction-memory request/grant/response channel
  logic                      mem_req_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic [31:0]               mem_rdata_i;

  // Downstream valid/ready instruction channel
  logic                      instr_valid_o;
  logic [31:0]               instr_o;
  logic [MEM_ADDR_WIDTH-1:0] instr_pc_o;
  logic                      instr_ready_i;

  // Redirect strobe and target operands from execute
  logic                      redirect_i;
  logic                      redirect_abs_i;
  logic [MEM_ADDR_WIDTH-1:0] redirect_base_i;
  logic [MEM_ADDR_WIDTH-1:0] redirect_offset_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i,
    input  redirect_i, redirect_abs_i, redirect_base_i, redirect_offset_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i,
    output redirect_i, redirect_abs_i, redirect_base_i, redirect_offset_i
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one memory fetch at a
// time, buffers the returned word for downstream and applies redirects,
// discarding any in-flight fetch that a redirect has made stale.
module fetch_sequencer #(
  parameter int                        MEM_ADDR_WIDTH = 10,
  parameter logic [MEM_ADDR_WIDTH-1:0] RESET_ADDR     = '0
) (
  input logic             clk,
  input logic             rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [MEM_ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                      discard_q, discard_d;
  logic                      valid_q, valid_d;
  logic [31:0]               instr_q, instr_d;
  logic [MEM_ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;

  logic [MEM_ADDR_WIDTH-1:0] target_raw;
  logic [MEM_ADDR_WIDTH-1:0] target;

  // Redirect target: absolute or base-relative, always word aligned
  always_comb begin
    target_raw = bus.redirect_abs_i ? bus.redirect_offset_i
                                    : bus.redirect_base_i + bus.redirect_offset_i;
    target     = {target_raw[MEM_ADDR_WIDTH-1:2], 2'b00};
  end

  // Next-state and next-register decode; a redirect overrides every other update
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      ST_REQ: begin
        if (bus.redirect_i) begin
          pc_d = target;
          if (bus.mem_gnt_i) begin
            req_pc_d  = pc_q;
            discard_d = 1'b1;
            state_d   = ST_WAIT;
          end
        end else if (bus.mem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + MEM_ADDR_WIDTH'(4);
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.redirect_i) begin
          pc_d = target;
          if (bus.mem_rvalid_i) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (bus.mem_rvalid_i) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            instr_d    = bus.mem_rdata_i;
            instr_pc_d = req_pc_q;
            valid_d    = 1'b1;
            state_d    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (bus.redirect_i) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else if (bus.instr_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_ADDR;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign bus.mem_req_o     = (state_q == ST_REQ) && !rst;
  assign bus.mem_addr_o    = pc_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_fetch_sequencer;

  localparam int              AW         = 10;
  localparam logic [AW-1:0]   RESET_ADDR = 10'h000;

  logic clk;
  logic rst;

  fetch_sequencer_if #(.MEM_ADDR_WIDTH(AW)) bus ();

  fetch_sequencer #(
    .MEM_ADDR_WIDTH(AW),
    .RESET_ADDR    (RESET_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: next fetch address, one outstanding fetch, output buffer
  bit          m_known   = 1'b0;
  logic [AW-1:0] m_pc;
  bit          m_out;
  logic [AW-1:0] m_out_addr;
  bit          m_stale;
  bit          m_buf_valid;
  logic [31:0] m_buf_data;
  logic [AW-1:0] m_buf_pc;

  logic [AW-1:0] last_req_addr;
  logic [AW-1:0] last_instr_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_req();
    return !rst && m_known && !m_out && !m_buf_valid;
  endfunction

  task automatic checkOutput();
    if (rst) begin
      chk("req_in_reset", 32'(bus.mem_req_o), 32'd0);
    end else if (m_known) begin
      chk("mem_req",     32'(bus.mem_req_o),     32'(model_req()));
      chk("mem_addr",    32'(bus.mem_addr_o),    32'(m_pc));
      chk("instr_valid", 32'(bus.instr_valid_o), 32'(m_buf_valid));
      chk("instr",       bus.instr_o,            m_buf_data);
      chk("instr_pc",    32'(bus.instr_pc_o),    32'(m_buf_pc));
    end
    if (bus.mem_req_o === 1'b1) last_req_addr = bus.mem_addr_o;
    if (bus.instr_valid_o === 1'b1) last_instr_pc = bus.instr_pc_o;
  endtask

  task automatic modelUpdate();
    logic [AW-1:0] tgt;
    bit granted, resp;
    if (rst) begin
      m_known     = 1'b1;
      m_pc        = RESET_ADDR;
      m_out       = 1'b0;
      m_stale     = 1'b0;
      m_buf_valid = 1'b0;
      m_buf_data  = '0;
      m_buf_pc    = '0;
    end else if (m_known) begin
      tgt = bus.redirect_abs_i ? bus.redirect_offset_i
                               : AW'(bus.redirect_base_i + bus.redirect_offset_i);
      tgt[1:0] = 2'b00;
      granted = model_req() && bus.mem_gnt_i;
      resp    = m_out && bus.mem_rvalid_i;
      if (resp) begin
        if (!m_stale && !bus.redirect_i) begin
          m_buf_valid = 1'b1;
          m_buf_data  = bus.mem_rdata_i;
          m_buf_pc    = m_out_addr;
        end else if (m_buf_valid && bus.redirect_i) begin
          m_buf_valid = 1'b0;
        end
        m_out   = 1'b0;
        m_stale = 1'b0;
      end else if (m_buf_valid && (bus.instr_ready_i || bus.redirect_i)) begin
        m_buf_valid = 1'b0;
      end
      if (granted) begin
        m_out      = 1'b1;
        m_out_addr = m_pc;
        m_stale    = 1'b0;
      end
      if (bus.redirect_i && m_out) m_stale = 1'b1;
      if (bus.redirect_i)   m_pc = tgt;
      else if (granted)     m_pc = AW'(m_pc + 4);
    end
  endtask

  // One clock cycle: drive mid-cycle, check, then advance the model at the edge
  task automatic applyStimulus(input bit r, input bit gnt, input bit rvalid,
                               input logic [31:0] rdata, input bit ready,
                               input bit redir, input bit abs_t,
                               input logic [AW-1:0] base, input logic [AW-1:0] off);
    @(negedge clk);
    rst                   = r;
    bus.mem_gnt_i         = gnt;
    bus.mem_rvalid_i      = rvalid;
    bus.mem_rdata_i       = rdata;
    bus.instr_ready_i     = ready;
    bus.redirect_i        = redir;
    bus.redirect_abs_i    = abs_t;
    bus.redirect_base_i   = base;
    bus.redirect_offset_i = off;
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic fetch_one(input logic [31:0] data);
    applyStimulus(0, 1, 0, '0,   0, 0, 0, '0, '0);
    applyStimulus(0, 0, 1, data, 0, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, '0,   1, 0, 0, '0, '0);
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    bus.instr_ready_i = 0; bus.redirect_i = 0; bus.redirect_abs_i = 0;
    bus.redirect_base_i = '0; bus.redirect_offset_i = '0;

    // Reset
    applyStimulus(1, 0, 0, '0, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, '0, 0, 0, 0, '0, '0);

    // Back-to-back fetches at 0x000, 0x004, 0x008
    for (int i = 0; i < 3; i++) begin
      last_req_addr = 'x;
      last_instr_pc = 'x;
      fetch_one(32'hA000_0000 + 32'(i));
      chk("seq_addr",     32'(last_req_addr), 32'(i * 4));
      chk("seq_instr_pc", 32'(last_instr_pc), 32'(i * 4));
    end

    // Downstream stall in HOLD for five cycles
    applyStimulus(0, 1, 0, '0, 0, 0, 0, '0, '0);
    applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, '0, '0);
    for (int i = 0; i < 5; i++) idle();
    chk("stall_pc", 32'(last_instr_pc), 32'h00C);
    applyStimulus(0, 0, 0, '0, 1, 0, 0, '0, '0);

    // Relative redirect while waiting: base 0x010, offset -8
    last_req_addr = 'x;
    applyStimulus(0, 1, 0, '0, 0, 0, 0, '0, '0);
    chk("after_stall_addr", 32'(last_req_addr), 32'h010);
    applyStimulus(0, 0, 0, '0, 0, 1, 0, 10'h010, 10'h3F8);
    applyStimulus(0, 0, 1, 32'h1111_1111, 0, 0, 0, '0, '0);
    last_req_addr = 'x;
    idle();
    chk("rel_redir_addr", 32'(last_req_addr), 32'h008);
    chk("rel_redir_novalid", 32'(bus.instr_valid_o), 32'd0);
    fetch_one(32'h2222_2222);

    // Absolute redirect coinciding with a grant
    applyStimulus(0, 1, 0, '0, 0, 1, 1, '0, 10'h103);
    applyStimulus(0, 0, 1, 32'h3333_3333, 0, 0, 0, '0, '0);
    last_req_addr = 'x;
    idle();
    chk("abs_redir_addr", 32'(last_req_addr), 32'h100);
    fetch_one(32'h4444_4444);

    // PC wrap from 0x3FC
    applyStimulus(0, 0, 0, '0, 0, 1, 1, '0, 10'h3FC);
    last_req_addr = 'x;
    last_instr_pc = 'x;
    fetch_one(32'h5555_5555);
    chk("wrap_fetch_addr", 32'(last_req_addr), 32'h3FC);
    chk("wrap_instr_pc",   32'(last_instr_pc), 32'h3FC);
    last_req_addr = 'x;
    idle();
    chk("wrap_next_addr", 32'(last_req_addr), 32'h000);

    // Reset during WAIT, then a late response
    applyStimulus(0, 1, 0, '0, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, '0, 0, 0, 0, '0, '0);
    last_req_addr = 'x;
    applyStimulus(0, 0, 1, 32'h6666_6666, 0, 0, 0, '0, '0);
    idle();
    chk("late_rvalid_novalid", 32'(bus.instr_valid_o), 32'd0);
    chk("late_rvalid_addr",    32'(last_req_addr), 32'(RESET_ADDR));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, g, rv, rd, rdr, ab;
      r   = ($urandom_range(0, 79) == 0);
      g   = model_req() ? 1'($urandom_range(0, 1)) : 1'b0;
      rv  = m_out ? ($urandom_range(0, 2) == 0) : 1'b0;
      rd  = 1'($urandom_range(0, 1));
      rdr = ($urandom_range(0, 7) == 0);
      ab  = 1'($urandom_range(0, 1));
      applyStimulus(r, g, rv, $urandom, rd, rdr, ab,
                    AW'($urandom), AW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
